// File: rtl/router_feeder_pkg.sv
// Shared constants and types for the router input-FIFO feeder.
// Also used by the router and its tester.
package router_feeder_pkg;

    localparam int DATA_W    = 8;
    localparam int DEST_W    = 2;
    localparam int WORD_W    = DEST_W + DATA_W;
    localparam int ERR_CNT_W = 4;

    localparam logic [DEST_W-1:0] DEST_FIFO0 = 2'd0;
    localparam logic [DEST_W-1:0] DEST_FIFO1 = 2'd1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Backpressure of the FIFO a legal destination maps to.
    function automatic logic target_full(
        input logic [DEST_W-1:0] dest,
        input logic              af0,
        input logic              af1
    );
        return (dest == DEST_FIFO1) ? af1 : af0;
    endfunction

endpackage

// File: rtl/router_feeder_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module router_feeder_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/router_feeder.sv
// Write end of the router input FIFOs: packs {dest,data}, honours
// almost-full with a one-word hold stage, drops illegal destinations.
module router_feeder
    import router_feeder_pkg::*;
#(
    parameter int DATA_W    = router_feeder_pkg::DATA_W,
    parameter int DEST_W    = router_feeder_pkg::DEST_W,
    parameter int ERR_CNT_W = router_feeder_pkg::ERR_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [DEST_W-1:0]        dest_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic                     fifo0_almost_full,
    input  logic                     fifo1_almost_full,
    output logic                     push_0,
    output logic                     push_1,
    output logic [DEST_W+DATA_W-1:0] out0,
    output logic [DEST_W+DATA_W-1:0] out1,
    output logic                     Error,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int W = DEST_W + DATA_W;

    state_t      state;
    logic [W-1:0] hold_word;
    logic [W-1:0] word;
    logic         take;
    logic         illegal;
    logic [DEST_W-1:0] hold_dest;

    assign word      = {dest_in, data_in};
    assign ready_in  = (state == IDLE) && !reset;
    assign take      = ready_in && valid_in;
    assign illegal   = dest_in[DEST_W-1];
    assign hold_dest = hold_word[W-1:DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_word <= '0;
            push_0    <= 1'b0;
            push_1    <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            Error     <= 1'b0;
        end else begin
            push_0 <= 1'b0;
            push_1 <= 1'b0;
            Error  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        if (illegal) begin
                            Error <= 1'b1;
                        end else if (target_full(dest_in, fifo0_almost_full,
                                                 fifo1_almost_full)) begin
                            hold_word <= word;
                            state     <= HOLD;
                        end else if (dest_in == DEST_FIFO1) begin
                            push_1 <= 1'b1;
                            out1   <= word;
                        end else begin
                            push_0 <= 1'b1;
                            out0   <= word;
                        end
                    end
                end
                HOLD: begin
                    // Only the held word's own FIFO can release it.
                    if (!target_full(hold_dest, fifo0_almost_full,
                                     fifo1_almost_full)) begin
                        state <= IDLE;
                        if (hold_dest == DEST_FIFO1) begin
                            push_1 <= 1'b1;
                            out1   <= hold_word;
                        end else begin
                            push_0 <= 1'b1;
                            out0   <= hold_word;
                        end
                    end
                end
            endcase
        end
    end

    router_feeder_sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (take && illegal),
        .count(err_count)
    );

endmodule
